// File: rtl/mini_rv_trace_pkg.sv
// Shared definitions for the commit trace recorder: FSM encoding, record field
// widths, mode selectors and the commit qualification rule.
package mini_rv_trace_pkg;

   localparam int REG_W = 5;
   localparam int SEQ_W = 16;

   localparam int FILTER_ALL   = 0;
   localparam int FILTER_REGWR = 1;

   localparam int STOP_DROP   = 0;
   localparam int STOP_FREEZE = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_STOPPED = 2'd2
   } state_e;

   // In register-write mode, commits that write nothing (or write x0) are ignored.
   function automatic logic commitQualifies(input logic have, input logic ena,
                                            input logic [REG_W-1:0] rd, input int filter);
      return have && ((filter != FILTER_REGWR) || (ena && (rd != '0)));
   endfunction

endpackage

// File: rtl/mini_rv_trace_fifo.sv
// Record FIFO accepting up to NCH writes and one read per cycle; the head entry
// is read combinationally so a record is visible the cycle after it is written.
module mini_rv_trace_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int NCH   = 1,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic [1:0]        pushNum_i,
   input  logic [NCH*W-1:0]  pushData_i,
   input  logic              pop_i,
   output logic [W-1:0]      head_o,
   output logic [AW:0]       count_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wrPtr_q, wrPtr_d;
   logic [AW:0]  rdPtr_q, rdPtr_d;
   logic         doPop;

   // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
   assign count_o = wrPtr_q - rdPtr_q;
   assign head_o  = mem_q[rdPtr_q[AW-1:0]];
   assign doPop   = pop_i && (count_o != '0);

   always_comb begin
      wrPtr_d = wrPtr_q + {{(AW-1){1'b0}}, pushNum_i};
      rdPtr_d = rdPtr_q + {{AW{1'b0}}, doPop};
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Storage is not reset; emptiness is tracked purely by the pointers.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (!flush_i && (k < int'(pushNum_i))) begin
            mem_q[wrPtr_q[AW-1:0] + AW'(k)] <= pushData_i[k*W +: W];
         end
      end
   end

endmodule

// File: rtl/mini_rv_trace.sv
// Commit trace recorder: qualifies retiring instructions, tags them with a running
// sequence number, buffers them, and accounts for records lost to a full buffer.
module mini_rv_trace
   import mini_rv_trace_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 16,
   parameter int NCH          = 1,
   parameter int FILTER       = 0,
   parameter int STOP_ON_FULL = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cap_en,
   input  logic                     clr,
   input  logic [NCH-1:0]           wb_have_inst,
   input  logic [NCH*XLEN-1:0]      wb_pc,
   input  logic [NCH-1:0]           wb_ena,
   input  logic [NCH*REG_W-1:0]     wb_reg,
   input  logic [NCH*XLEN-1:0]      wb_value,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic                     out_ena,
   output logic [REG_W-1:0]         out_reg,
   output logic [XLEN-1:0]          out_value,
   output logic [SEQ_W-1:0]         out_seq,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [SEQ_W-1:0]         drop_cnt,
   output logic [1:0]               state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = XLEN + 1 + REG_W + XLEN + SEQ_W;

   state_e            state_q, state_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [SEQ_W-1:0]  dropCnt_q, dropCnt_d;
   logic              overflow_q, overflow_d;

   logic [NCH-1:0]    qual;
   logic [1:0]        numQual, numAcc, numDrop, pushNum;
   logic [NCH*RW-1:0] pushData;
   logic [CW:0]       freeSlots, cntAfter;
   logic [SEQ_W:0]    dropSum;
   logic              popNow;
   logic [RW-1:0]     headRec;
   logic [CW-1:0]     fifoCount;

   // Qualifying commits are packed into consecutive slots in channel order,
   // each tagged with the next sequence number.
   always_comb begin
      int slot;
      slot     = 0;
      qual     = '0;
      pushData = '0;
      for (int c = 0; c < NCH; c++) begin
         qual[c] = (state_q == ST_CAPTURE) &&
                   commitQualifies(wb_have_inst[c], wb_ena[c], wb_reg[c*REG_W +: REG_W], FILTER);
         if (qual[c]) begin
            pushData[slot*RW +: RW] = {wb_pc[c*XLEN +: XLEN], wb_ena[c], wb_reg[c*REG_W +: REG_W],
                                       wb_value[c*XLEN +: XLEN], seq_q + SEQ_W'(slot)};
            slot = slot + 1;
         end
      end
      numQual = 2'(slot);
   end

   // Room is judged after this cycle's pop; low channels win when space runs short.
   assign popNow    = out_valid && out_ready;
   assign freeSlots = (CW+1)'(DEPTH) - {1'b0, fifoCount} + {{CW{1'b0}}, popNow};
   assign numAcc    = ({{(CW-1){1'b0}}, numQual} <= freeSlots) ? numQual : freeSlots[1:0];
   assign numDrop   = numQual - numAcc;
   assign cntAfter  = {1'b0, fifoCount} - {{CW{1'b0}}, popNow} + {{(CW-1){1'b0}}, numAcc};
   assign dropSum   = {1'b0, dropCnt_q} + {{(SEQ_W-1){1'b0}}, numDrop};
   assign pushNum   = clr ? 2'd0 : numAcc;

   // Capture control plus sequence/drop bookkeeping; clr overrides everything.
   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q + {{(SEQ_W-2){1'b0}}, numQual};
      dropCnt_d  = dropSum[SEQ_W] ? '1 : dropSum[SEQ_W-1:0];
      overflow_d = overflow_q | (numDrop != 2'd0);
      unique case (state_q)
         ST_IDLE: begin
            if (cap_en) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (!cap_en) begin
               state_d = ST_IDLE;
            end else if ((STOP_ON_FULL == STOP_FREEZE) && (cntAfter == (CW+1)'(DEPTH))) begin
               state_d = ST_STOPPED;
            end
         end
         ST_STOPPED: state_d = ST_STOPPED;
         default:    state_d = ST_IDLE;
      endcase
      if (clr) begin
         state_d    = ST_IDLE;
         seq_d      = '0;
         dropCnt_d  = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         seq_q      <= '0;
         dropCnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         dropCnt_q  <= dropCnt_d;
         overflow_q <= overflow_d;
      end
   end

   mini_rv_trace_fifo #(
      .W     (RW),
      .DEPTH (DEPTH),
      .NCH   (NCH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (clr),
      .pushNum_i  (pushNum),
      .pushData_i (pushData),
      .pop_i      (popNow),
      .head_o     (headRec),
      .count_o    (fifoCount)
   );

   // An empty FIFO presents an all-zero record rather than stale storage.
   assign out_valid = (fifoCount != '0);
   assign {out_pc, out_ena, out_reg, out_value, out_seq} = out_valid ? headRec : '0;
   assign count     = fifoCount;
   assign overflow  = overflow_q;
   assign drop_cnt  = dropCnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_mini_rv_trace.sv
// Bench for the trace recorder: four configurations share one stimulus stream and
// are compared every cycle against a queue-based reference plus literal spot checks.
module tb_mini_rv_trace;

   localparam int NI = 4;
   localparam int MD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clr, capEn, outReady;
   logic [1:0]  wbHave, wbEna;
   logic [63:0] wbPc, wbValue;
   logic [9:0]  wbReg;

   logic        outValid [NI];
   logic [31:0] outPc    [NI];
   logic        outEna   [NI];
   logic [4:0]  outReg   [NI];
   logic [31:0] outValue [NI];
   logic [15:0] outSeq   [NI];
   logic [2:0]  cnt      [NI];
   logic        ovf      [NI];
   logic [15:0] dropCnt  [NI];
   logic [1:0]  st       [NI];

   int checks = 0;
   int errors = 0;
   bit chkEn  = 1'b0;

   // Instance 0: plain, 1: register-write filter, 2: freeze on full (all single channel).
   for (genvar gi = 0; gi < 3; gi++) begin : g1
      mini_rv_trace #(.XLEN(32), .DEPTH(MD), .NCH(1), .FILTER(gi == 1 ? 1 : 0),
                      .STOP_ON_FULL(gi == 2 ? 1 : 0)) dut (
         .clk(clk), .rst(rst), .cap_en(capEn), .clr(clr),
         .wb_have_inst(wbHave[0:0]), .wb_pc(wbPc[31:0]), .wb_ena(wbEna[0:0]),
         .wb_reg(wbReg[4:0]), .wb_value(wbValue[31:0]),
         .out_valid(outValid[gi]), .out_ready(outReady), .out_pc(outPc[gi]),
         .out_ena(outEna[gi]), .out_reg(outReg[gi]), .out_value(outValue[gi]),
         .out_seq(outSeq[gi]), .count(cnt[gi]), .overflow(ovf[gi]),
         .drop_cnt(dropCnt[gi]), .state(st[gi]));
   end

   mini_rv_trace #(.XLEN(32), .DEPTH(MD), .NCH(2), .FILTER(0), .STOP_ON_FULL(0)) u_dual (
      .clk(clk), .rst(rst), .cap_en(capEn), .clr(clr),
      .wb_have_inst(wbHave), .wb_pc(wbPc), .wb_ena(wbEna), .wb_reg(wbReg), .wb_value(wbValue),
      .out_valid(outValid[3]), .out_ready(outReady), .out_pc(outPc[3]),
      .out_ena(outEna[3]), .out_reg(outReg[3]), .out_value(outValue[3]),
      .out_seq(outSeq[3]), .count(cnt[3]), .overflow(ovf[3]),
      .drop_cnt(dropCnt[3]), .state(st[3]));

   typedef struct packed {
      logic [31:0] pc;
      logic        ena;
      logic [4:0]  rg;
      logic [31:0] val;
      logic [15:0] seq;
   } rec_t;

   rec_t mRec [NI][512];
   int   mHead [NI];
   int   mTail [NI];
   int   mSeq [NI];
   int   mDrop [NI];
   int   mState [NI];
   bit   mOvf [NI];

   function automatic int cfgNch(input int i);
      return (i == 3) ? 2 : 1;
   endfunction

   // Reference behaviour: pop first, then each qualifying commit in channel order
   // takes a sequence number and is either queued or counted as lost.
   task automatic modelStep();
      int nq, occ, oldState;
      bool_loop: for (int i = 0; i < NI; i++) begin
         if (rst) begin
            mHead[i] = 0; mTail[i] = 0; mSeq[i] = 0; mDrop[i] = 0; mOvf[i] = 0; mState[i] = 0;
         end else if (clr) begin
            mHead[i] = mTail[i]; mSeq[i] = 0; mDrop[i] = 0; mOvf[i] = 0; mState[i] = 0;
         end else begin
            oldState = mState[i];
            nq = 0;
            if (outReady && (mTail[i] > mHead[i])) mHead[i]++;
            for (int ch = 0; ch < cfgNch(i); ch++) begin
               if (oldState == 1 && wbHave[ch] &&
                   (i != 1 || (wbEna[ch] && wbReg[ch*5 +: 5] != 5'd0))) begin
                  if (mTail[i] - mHead[i] < MD) begin
                     mRec[i][mTail[i]] = {wbPc[ch*32 +: 32], wbEna[ch], wbReg[ch*5 +: 5],
                                          wbValue[ch*32 +: 32], 16'((mSeq[i] + nq) % 65536)};
                     mTail[i]++;
                  end else begin
                     mDrop[i] = (mDrop[i] < 65535) ? mDrop[i] + 1 : 65535;
                     mOvf[i]  = 1'b1;
                  end
                  nq++;
               end
            end
            mSeq[i] = (mSeq[i] + nq) % 65536;
            occ = mTail[i] - mHead[i];
            if (oldState == 0 && capEn) mState[i] = 1;
            else if (oldState == 1 && !capEn) mState[i] = 0;
            else if (oldState == 1 && i == 2 && occ == MD) mState[i] = 2;
         end
      end
   endtask

   always @(posedge clk) modelStep();

   task automatic checkOutput(input string name, input int inst, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s inst%0d actual=%0h required=%0h t=%0t", name, inst, act, exp, $time);
      end
   endtask

   task automatic compareInstance(input int i);
      int   occ;
      rec_t r;
      occ = mTail[i] - mHead[i];
      checkOutput("valid", i, outValid[i], occ != 0);
      checkOutput("count", i, cnt[i], occ);
      checkOutput("overflow", i, ovf[i], mOvf[i]);
      checkOutput("drop_cnt", i, dropCnt[i], mDrop[i]);
      checkOutput("state", i, st[i], mState[i]);
      if (occ != 0) begin
         r = mRec[i][mHead[i]];
         checkOutput("out_pc", i, outPc[i], r.pc);
         checkOutput("out_ena", i, outEna[i], r.ena);
         checkOutput("out_reg", i, outReg[i], r.rg);
         checkOutput("out_value", i, outValue[i], r.val);
         checkOutput("out_seq", i, outSeq[i], r.seq);
      end
   endtask

   always @(negedge clk) begin
      if (chkEn) begin
         for (int i = 0; i < NI; i++) compareInstance(i);
      end
   end

   // Drives one cycle of commit inputs and returns at the following falling edge.
   task automatic applyStimulus(input logic [1:0] have, input logic [31:0] pc0, input logic ena0,
                                input logic [4:0] reg0, input logic [31:0] pc1,
                                input logic ena1, input logic [4:0] reg1);
      wbHave  = have;
      wbPc    = {pc1, pc0};
      wbEna   = {ena1, ena0};
      wbReg   = {reg1, reg0};
      wbValue = {pc1 ^ 32'hA5A5_0000, pc0 ^ 32'h5A5A_0000};
      @(negedge clk);
   endtask

   task automatic idleCycle();
      applyStimulus(2'b00, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
   endtask

   task automatic commitOne(input logic [31:0] pc, input logic ena, input logic [4:0] rd);
      applyStimulus(2'b01, pc, ena, rd, 32'h0, 1'b0, 5'd0);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; capEn = 1'b0; outReady = 1'b0;
      wbHave = '0; wbEna = '0; wbPc = '0; wbValue = '0; wbReg = '0;
      @(negedge clk);
      @(negedge clk);
      chkEn = 1'b1;
      checkOutput("rst_valid", 0, outValid[0], 0);
      checkOutput("rst_count", 0, cnt[0], 0);
      checkOutput("rst_state", 0, st[0], 0);
      checkOutput("rst_pc", 0, outPc[0], 0);
      checkOutput("rst_seq", 0, outSeq[0], 0);
      checkOutput("rst_drop", 0, dropCnt[0], 0);
      rst = 1'b0;

      // Three back-to-back commits drained immediately.
      capEn = 1'b1;
      idleCycle();
      outReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         commitOne(32'(4 * k), 1'b1, 5'd1);
         checkOutput("lat1_valid", 0, outValid[0], 1);
         checkOutput("lat1_pc", 0, outPc[0], 4 * k);
         checkOutput("lat1_seq", 0, outSeq[0], k);
      end
      idleCycle();
      checkOutput("drained", 0, cnt[0], 0);

      // Register-write filter.
      clr = 1'b1; idleCycle(); clr = 1'b0; idleCycle();
      outReady = 1'b0;
      commitOne(32'h10, 1'b1, 5'd5);
      commitOne(32'h14, 1'b0, 5'd6);
      commitOne(32'h18, 1'b1, 5'd0);
      commitOne(32'h1C, 1'b1, 5'd7);
      checkOutput("filt_count", 1, cnt[1], 2);
      checkOutput("filt_reg0", 1, outReg[1], 5);
      checkOutput("filt_seq0", 1, outSeq[1], 0);
      outReady = 1'b1;
      idleCycle();
      checkOutput("filt_reg1", 1, outReg[1], 7);
      checkOutput("filt_seq1", 1, outSeq[1], 1);
      for (int k = 0; k < 4; k++) idleCycle();

      // Overflow with drops, and freeze-on-full in instance 2.
      clr = 1'b1; idleCycle(); clr = 1'b0; idleCycle();
      outReady = 1'b0;
      for (int k = 0; k < 6; k++) begin
         commitOne(32'h100 + 32'(4 * k), 1'b1, 5'd2);
         if (k == 3) checkOutput("stop_state", 2, st[2], 2);
      end
      checkOutput("ovf_count", 0, cnt[0], 4);
      checkOutput("ovf_drop", 0, dropCnt[0], 2);
      checkOutput("ovf_flag", 0, ovf[0], 1);
      checkOutput("stop_count", 2, cnt[2], 4);
      checkOutput("stop_drop", 2, dropCnt[2], 0);
      outReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checkOutput("ovf_drain_seq", 0, outSeq[0], k);
         idleCycle();
      end
      checkOutput("stop_held", 2, st[2], 2);
      commitOne(32'h200, 1'b1, 5'd3);
      checkOutput("ovf_next_seq", 0, outSeq[0], 6);
      clr = 1'b1; idleCycle(); clr = 1'b0;
      checkOutput("stop_cleared", 2, st[2], 0);

      // Dual channel: simultaneous pop makes room for both, otherwise channel 1 is lost.
      idleCycle();
      outReady = 1'b0;
      for (int k = 0; k < 3; k++) commitOne(32'h300 + 32'(4 * k), 1'b1, 5'd4);
      checkOutput("dual_pre", 3, cnt[3], 3);
      outReady = 1'b1;
      applyStimulus(2'b11, 32'h400, 1'b1, 5'd8, 32'h404, 1'b1, 5'd9);
      checkOutput("dual_pop_count", 3, cnt[3], 4);
      checkOutput("dual_pop_drop", 3, dropCnt[3], 0);
      idleCycle();
      outReady = 1'b0;
      applyStimulus(2'b11, 32'h500, 1'b1, 5'd10, 32'h504, 1'b1, 5'd11);
      checkOutput("dual_full_count", 3, cnt[3], 4);
      checkOutput("dual_full_drop", 3, dropCnt[3], 1);
      checkOutput("dual_full_ovf", 3, ovf[3], 1);

      // Reset in the middle of a capture.
      clr = 1'b1; idleCycle(); clr = 1'b0; idleCycle();
      for (int k = 0; k < 3; k++) commitOne(32'h600 + 32'(4 * k), 1'b1, 5'd12);
      checkOutput("mid_count", 0, cnt[0], 3);
      rst = 1'b1; idleCycle(); rst = 1'b0;
      checkOutput("mid_rst_count", 0, cnt[0], 0);
      checkOutput("mid_rst_valid", 0, outValid[0], 0);
      checkOutput("mid_rst_state", 0, st[0], 0);
      idleCycle();
      outReady = 1'b1;
      commitOne(32'h700, 1'b1, 5'd13);
      checkOutput("post_rst_seq", 0, outSeq[0], 0);
      checkOutput("post_rst_pc", 0, outPc[0], 32'h700);
      idleCycle();
      idleCycle();

      chkEn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mini_rv_trace.md
MINI_RV_TRACE -- requirements
Module: mini_rv_trace

Interface
REQ-001 Parameter XLEN, default 32, datapath/PC width.
REQ-002 Parameter DEPTH, default 16, record FIFO depth (power of 2, >=4).
REQ-003 Parameter NCH, default 1, commit channels per cycle (1 or 2).
REQ-004 Parameter FILTER, default 0: 0 = record every commit; 1 = record only register writes (ena=1, reg!=0).
REQ-005 Parameter STOP_ON_FULL, default 0: 0 = drop on full, keep capturing; 1 = freeze capture when full.
REQ-006 Ports: clk in 1, system clock; rst in 1, synchronous active-high reset.
REQ-007 Port cap_en, in, 1: arm capture.
REQ-008 Port clr, in, 1: flush FIFO and counters, return to IDLE.
REQ-009 Port wb_have_inst, in, NCH: per-channel commit valid.
REQ-010 Ports wb_pc, in, NCH*XLEN; wb_ena, in, NCH; wb_reg, in, NCH*5; wb_value, in, NCH*XLEN: per-channel commit record, channel 0 in the LSBs.
REQ-011 Ports out_valid, out, 1, and out_ready, in, 1: record output handshake.
REQ-012 Ports out_pc, out, XLEN; out_ena, out, 1; out_reg, out, 5; out_value, out, XLEN; out_seq, out, 16: head record.
REQ-013 Ports count, out, log2(DEPTH)+1: occupancy; overflow, out, 1: sticky drop flag; drop_cnt, out, 16: saturating drop count; state, out, 2: FSM state.

Function
REQ-014 FSM states: IDLE=0, CAPTURE=1, STOPPED=2.
REQ-015 Transitions: IDLE->CAPTURE when cap_en=1; CAPTURE->IDLE when cap_en=0; CAPTURE->STOPPED when STOP_ON_FULL=1 and the FIFO becomes full; STOPPED->IDLE only on clr. clr has priority over every transition.
REQ-016 A channel qualifies when state=CAPTURE, its wb_have_inst=1, and, if FILTER=1, its wb_ena=1 with wb_reg!=0.
REQ-017 Every qualifying commit takes the next out_seq value; seq increments by the number of qualifying channels per cycle, wraps modulo 2^16, and is shared by accepted and dropped records so that gaps expose drops.
REQ-018 Qualifying records are written in channel order (0 before 1); a record becomes visible on out_* the cycle after it is written (latency 1).
REQ-019 Free slots are computed after the same-cycle pop: a pop (out_valid and out_ready) and a push of up to NCH records occur in the same cycle.
REQ-020 When free slots < qualifying records, the lowest channels are accepted, the rest are dropped; drop_cnt adds the dropped number (saturating at 0xFFFF) and overflow is set.
REQ-021 out_valid=1 iff count!=0; out_* hold stable while out_valid=1 and out_ready=0.
REQ-022 In IDLE and STOPPED no records are written; draining continues in every state.
REQ-023 clr empties the FIFO and zeroes seq, drop_cnt and overflow in the following cycle, discarding any same-cycle push.
REQ-024 Read/write pointers have log2(DEPTH)+1 bits; wrap-around of the pointers is transparent to count.

Reset
REQ-025 On rst: state=IDLE, count=0, out_valid=0, overflow=0, drop_cnt=0, seq=0, pointers=0; out_pc, out_reg, out_value, out_ena, out_seq read 0.
REQ-026 rst mid-capture discards all stored records; the first post-reset record carries out_seq=0.

Structure
REQ-027 The shared package holds the state encoding, the record field widths (REG_W=5, SEQ_W=16), and the FILTER/STOP_ON_FULL mode constants.
REQ-028 One sub-module, mini_rv_trace_fifo: a multi-push (NCH), single-pop FIFO with count; FSM, qualification, and seq/drop logic live in the top.

Verification
REQ-029 NCH=1, FILTER=0: cap_en=1, 3 commits pc=0x0,0x4,0x8, out_ready=1 -> three records, out_seq 0,1,2, each one cycle after input.
REQ-030 FILTER=1: commits (ena=1,reg=5), (ena=0,reg=6), (ena=1,reg=0), (ena=1,reg=7) -> only reg 5 and 7 are output, with out_seq 0,1.
REQ-031 DEPTH=4, out_ready=0, 6 commits -> count=4, drop_cnt=2, overflow=1; after draining, out_seq reads 0..3 and the next accepted record is 6.
REQ-032 STOP_ON_FULL=1, DEPTH=4, 5 commits -> state=STOPPED after the 4th, 5th is not counted; drain leaves state=STOPPED until clr, then IDLE.
REQ-033 NCH=2, count=DEPTH-1, both channels commit with a simultaneous pop -> both accepted, count=DEPTH, no drop; without the pop -> channel 0 is accepted, drop_cnt=1.
REQ-034 rst asserted with count=3 mid-capture -> next cycle count=0, out_valid=0, state=IDLE; re-arm and first record out_seq=0.
